// File: rtl/axi_wr_responder.sv
// AXI4-Lite write responder: collects one AW and one W beat in either order, commits the
// strobed data into a small register file, and returns a B response. One write outstanding at a time.
`timescale 1ns/1ps
module axi_wr_responder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 16
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [ADDR_W-1:0]        AWADDR,
  input  logic                     WVALID,
  output logic                     WREADY,
  input  logic [DATA_W-1:0]        WDATA,
  input  logic [DATA_W/8-1:0]      WSTRB,
  output logic                     BVALID,
  input  logic                     BREADY,
  output logic [1:0]               BRESP,
  input  logic                     mem_hold,
  input  logic [$clog2(DEPTH)-1:0] dbg_addr,
  output logic [DATA_W-1:0]        dbg_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {S_COLLECT, S_COMMIT, S_RESP} state_e;

  state_e              state_q, state_d;
  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic                aw_held_q, aw_held_d;
  logic                w_held_q, w_held_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [ADDR_W-1:0]   widx_q, widx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];

  logic aw_hs, w_hs, in_range;

  // READYs are registered, so a handshake only needs the registered ready and the master's VALID.
  assign aw_hs    = AWVALID && awready_q;
  assign w_hs     = WVALID && wready_q;
  // Full word index is kept so addresses beyond the file are rejected, not aliased.
  assign in_range = (widx_q < ADDR_W'(DEPTH));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d   = state_q;
    awready_d = 1'b0;
    wready_d  = 1'b0;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    widx_d    = widx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    mem_d     = mem_q;

    case (state_q)
      S_COLLECT: begin
        if (aw_hs) begin
          widx_d    = AWADDR >> OFF_W;
          aw_held_d = 1'b1;
        end
        if (w_hs) begin
          wdata_d  = WDATA;
          wstrb_d  = WSTRB;
          w_held_d = 1'b1;
        end
        if (aw_held_d && w_held_d) begin
          state_d = S_COMMIT;
        end else begin
          awready_d = !aw_held_d;
          wready_d  = !w_held_d;
        end
      end
      S_COMMIT: begin
        if (!mem_hold) begin
          if (in_range) begin
            for (int i = 0; i < STRB_W; i++) begin
              if (wstrb_q[i]) mem_d[widx_q[IDX_W-1:0]][8*i +: 8] = wdata_q[8*i +: 8];
            end
            bresp_d = RESP_OKAY;
          end else begin
            bresp_d = RESP_SLVERR;
          end
          bvalid_d = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (BREADY) begin
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          state_d   = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= S_COLLECT;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      widx_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      // NOTE: the register file must read zero after reset, so it is built from resettable flops, not RAM.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      widx_q    <= widx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      mem_q     <= mem_d;
    end
  end

  assign AWREADY   = awready_q;
  assign WREADY    = wready_q;
  assign BVALID    = bvalid_q;
  assign BRESP     = bresp_q;
  assign dbg_rdata = mem_q[dbg_addr];

endmodule

// File: tb/tb_axi_wr_responder.sv
// Directed bench for axi_wr_responder: expected B responses go into a scoreboard queue that a
// negedge monitor drains on each B handshake; register contents are checked through the debug port.
`timescale 1ns/1ps
module tb_axi_wr_responder;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        AWVALID, WVALID, BREADY, mem_hold;
  logic [11:0] AWADDR;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic [3:0]  dbg_addr;
  logic        AWREADY, WREADY, BVALID;
  logic [1:0]  BRESP;
  logic [31:0] dbg_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q [$];

  axi_wr_responder #(.DATA_W(32), .ADDR_W(12), .DEPTH(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .mem_hold(mem_hold), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check_word(input logic [3:0] idx, input logic [31:0] exp);
    dbg_addr = idx;
    #1;
    check($sformatf("word%0d", idx), dbg_rdata, exp);
  endtask

  task automatic write_both(input logic [11:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] resp);
    bit aw_p = 1'b1;
    bit w_p  = 1'b1;
    bit aw_f, w_f;
    int n = 0;
    exp_q.push_back(resp);
    AWADDR = addr; WDATA = data; WSTRB = strb;
    AWVALID = 1'b1; WVALID = 1'b1;
    while ((aw_p || w_p) && n < 50) begin
      aw_f = aw_p && AWREADY;
      w_f  = w_p && WREADY;
      cyc();
      n++;
      if (aw_f) begin aw_p = 1'b0; AWVALID = 1'b0; end
      if (w_f)  begin w_p  = 1'b0; WVALID  = 1'b0; end
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    check("wr_accept", {aw_p, w_p}, 2'b00);
  endtask

  task automatic send_aw(input logic [11:0] addr);
    int n = 0;
    AWADDR = addr; AWVALID = 1'b1;
    while (!AWREADY && n < 50) begin cyc(); n++; end
    check("aw_ready_seen", AWREADY, 1'b1);
    cyc();
    AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    WDATA = data; WSTRB = strb; WVALID = 1'b1;
    while (!WREADY && n < 50) begin cyc(); n++; end
    check("w_ready_seen", WREADY, 1'b1);
    cyc();
    WVALID = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(AWREADY && WREADY) && n < 50) begin cyc(); n++; end
    check("idle", AWREADY && WREADY, 1'b1);
  endtask

  // Monitor: a B handshake happens at the next rising edge whenever BVALID && BREADY here.
  always @(negedge ACLK) begin
    if (ARESETn === 1'b1 && BVALID === 1'b1 && BREADY === 1'b1) begin
      if (exp_q.size() == 0) check("sb_nonempty", 64'(exp_q.size()), 64'd1);
      else                   check("bresp", BRESP, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETn = 1'b0; AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0; mem_hold = 1'b0;
    AWADDR = '0; WDATA = '0; WSTRB = '0; dbg_addr = '0;

    // 1: reset values, readies rise on first edge after release, same-edge AW+W
    #12;
    check("rst_awready", AWREADY, 1'b0);
    check("rst_wready", WREADY, 1'b0);
    check("rst_bvalid", BVALID, 1'b0);
    check("rst_bresp", BRESP, 2'b00);
    cyc();
    ARESETn = 1'b1;
    #1;
    check("pre_edge_awready", AWREADY, 1'b0);
    cyc();
    check("post_rst_awready", AWREADY, 1'b1);
    check("post_rst_wready", WREADY, 1'b1);
    BREADY = 1'b1;
    write_both(12'h008, 32'hDEADBEEF, 4'hF, 2'b00);
    check("commit_bvalid_low", BVALID, 1'b0);
    check("commit_awready_low", AWREADY, 1'b0);
    cyc();
    check("lat_bvalid", BVALID, 1'b1);
    check("lat_bresp", BRESP, 2'b00);
    check_word(4'd2, 32'hDEADBEEF);
    cyc();
    check("b_done_bvalid", BVALID, 1'b0);
    check("b_done_awready", AWREADY, 1'b1);
    check("b_done_wready", WREADY, 1'b1);

    // 2: W three cycles ahead of AW
    exp_q.push_back(2'b00);
    send_w(32'h11223344, 4'hF);
    check("w_first_wready", WREADY, 1'b0);
    check("w_first_awready", AWREADY, 1'b1);
    repeat (3) begin
      cyc();
      check("w_held_wready", WREADY, 1'b0);
    end
    send_aw(12'h004);
    wait_idle();
    check_word(4'd1, 32'h11223344);

    // 3: out-of-range SLVERR, strobed and sub-word addressed writes
    write_both(12'h0C0, 32'hFFFFFFFF, 4'hF, 2'b10);
    wait_idle();
    check_word(4'd0, 32'h00000000);
    check_word(4'd1, 32'h11223344);
    check_word(4'd2, 32'hDEADBEEF);
    write_both(12'h000, 32'h12345678, 4'b0010, 2'b00);
    wait_idle();
    check_word(4'd0, 32'h00005600);
    write_both(12'h004, 32'h00000000, 4'b0000, 2'b00);
    wait_idle();
    check_word(4'd1, 32'h11223344);
    write_both(12'h00B, 32'h00000000, 4'b1001, 2'b00);
    wait_idle();
    check_word(4'd2, 32'h00ADBE00);

    // 4: mem_hold stalls the commit for 5 edges
    mem_hold = 1'b1;
    write_both(12'h00C, 32'hCAFEF00D, 4'hF, 2'b00);
    for (int i = 0; i < 5; i++) begin
      check("hold_awready", AWREADY, 1'b0);
      check("hold_wready", WREADY, 1'b0);
      check("hold_bvalid", BVALID, 1'b0);
      check_word(4'd3, 32'h00000000);
      cyc();
    end
    mem_hold = 1'b0;
    check("hold_release_bvalid", BVALID, 1'b0);
    cyc();
    check("hold_done_bvalid", BVALID, 1'b1);
    check_word(4'd3, 32'hCAFEF00D);
    wait_idle();

    // 5: BREADY low for 4 cycles with a competing AW
    BREADY = 1'b0;
    write_both(12'h010, 32'h0BADF00D, 4'hF, 2'b00);
    cyc();
    AWADDR = 12'h014; AWVALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp_bvalid", BVALID, 1'b1);
      check("bp_bresp", BRESP, 2'b00);
      check("bp_awready", AWREADY, 1'b0);
      check("bp_wready", WREADY, 1'b0);
      cyc();
    end
    AWVALID = 1'b0;
    BREADY = 1'b1;
    check("bp_release_bvalid", BVALID, 1'b1);
    cyc();
    check("bp_after_bvalid", BVALID, 1'b0);
    check("bp_after_awready", AWREADY, 1'b1);
    check("bp_after_wready", WREADY, 1'b1);
    check_word(4'd4, 32'h0BADF00D);

    // 6: reset during RESP discards the response and clears the file
    BREADY = 1'b0;
    write_both(12'h018, 32'h55AA55AA, 4'hF, 2'b00);
    cyc();
    check("pre_rst_bvalid", BVALID, 1'b1);
    ARESETn = 1'b0;
    #1;
    check("mid_rst_bvalid", BVALID, 1'b0);
    check("mid_rst_awready", AWREADY, 1'b0);
    check("mid_rst_wready", WREADY, 1'b0);
    check("mid_rst_bresp", BRESP, 2'b00);
    exp_q.delete();
    check_word(4'd6, 32'h00000000);
    check_word(4'd2, 32'h00000000);
    cyc();
    ARESETn = 1'b1;
    cyc();
    BREADY = 1'b1;
    write_both(12'h01C, 32'h01020304, 4'hF, 2'b00);
    wait_idle();
    check_word(4'd7, 32'h01020304);
    check_word(4'd6, 32'h00000000);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
